// File: rtl/recip_nr.sv
// recip_nr: fixed-point reciprocal y = 1/x in signed Q(W-F).F using a
// seed table followed by ITER Newton-Raphson refinements.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand strobe; accepted when in_ready is high
//   in_ready   high only while idle
//   x_in       signed operand, Q(W-F).F
//   out_valid  result valid; held until out_ready
//   out_ready  downstream accepts result
//   y_out      signed reciprocal, Q(W-F).F
//   out_err    operand was zero, or negative with SIGNED_MODE=0
//   out_sat    result magnitude clipped to the largest positive value
//   busy       high in every state except idle
module recip_nr #(
   parameter int W           = 32,
   parameter int F           = 16,
   parameter int ITER        = 3,
   parameter int LUT_BITS    = 4,
   parameter int SIGNED_MODE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y_out,
   output logic         out_err,
   output logic         out_sat,
   output logic         busy
);

   localparam int YW    = W + 2;               // unsigned Q2.W estimate
   localparam int PW    = 2 * YW;              // shared multiplier product
   localparam int DW    = 2 * W + 2;           // denormalisation headroom
   localparam int LZW   = $clog2(W) + 1;
   localparam int SW    = $clog2(2 * W + 1) + 1;
   localparam int LUT_N = 2 ** LUT_BITS;

   localparam logic [YW-1:0] TWO_Q  = {2'b10, {W{1'b0}}};
   localparam logic [W-1:0]  MAXPOS = {1'b0, {(W-1){1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_NORM,
      S_SEED,
      S_ITER,
      S_DENORM,
      S_OUT
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_sign;
   logic [W-1:0]          r_mag;      // |x| at accept, normalised mantissa after NORM
   logic signed [SW-1:0]  r_shift;    // W-F+e, final right-shift amount
   logic [YW-1:0]         r_y;
   logic [YW-1:0]         r_t;
   logic                  r_phase;
   logic [2:0]            r_cnt;
   logic [W-1:0]          r_y_out;
   logic                  r_err;
   logic                  r_sat;

   logic                  w_accept;
   logic                  w_bad;
   logic [LZW-1:0]        w_lz;
   logic [YW-1:0]         w_lut [LUT_N];
   logic [YW-1:0]         w_mul_b;
   logic [PW-1:0]         w_prod;
   logic [YW-1:0]         w_prod_sh;
   logic [SW-1:0]         w_shamt;
   logic [DW-1:0]         w_mag;
   logic                  w_sat;
   logic [W-1:0]          w_r;

   // round(2^(W+L+1) / (2^L + i + 0.5)), written with an odd divisor so the
   // half-up rounding never meets an exact tie.
   function automatic logic [YW-1:0] seed_val(input int unsigned idx);
      logic [127:0] num;
      logic [127:0] den;
      logic [127:0] q;
      num = 128'd1 << (W + LUT_BITS + 2);
      den = (128'd1 << (LUT_BITS + 1)) + 128'(2 * idx + 1);
      q   = (num + (den >> 1)) / den;
      return q[YW-1:0];
   endfunction

   for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      assign w_lut[gi] = seed_val(gi);
   end

   assign y_out   = r_y_out;
   assign out_err = r_err;
   assign out_sat = r_sat;

   assign w_bad = (r_mag == '0) || (r_sign && (SIGNED_MODE == 0));

   always_comb begin
      w_lz = LZW'(W);
      for (int unsigned k = 0; k < W; k++) begin
         if (r_mag[k]) w_lz = LZW'(W - 1 - k);
      end
   end

   // One multiplier serves both halves of an iteration:
   // phase 0 forms t = m*y, phase 1 forms y*(2 - t).
   assign w_mul_b   = r_phase ? (TWO_Q - r_t) : {2'b00, r_mag};
   assign w_prod    = PW'(r_y) * PW'(w_mul_b);
   assign w_prod_sh = YW'(w_prod >> W);

   assign w_shamt = r_shift[SW-1] ? SW'(-r_shift) : SW'(r_shift);
   assign w_mag   = r_shift[SW-1] ? (DW'(r_y) << w_shamt) : (DW'(r_y) >> w_shamt);
   assign w_sat   = (w_mag > DW'(MAXPOS));
   assign w_r     = w_sat ? MAXPOS : W'(w_mag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      w_accept  = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            w_accept = in_valid;
            if (in_valid) w_next = S_NORM;
         end
         S_NORM:   w_next = w_bad ? S_OUT : S_SEED;
         S_SEED:   w_next = S_ITER;
         S_ITER: begin
            if (r_phase && (r_cnt == 3'(ITER - 1))) w_next = S_DENORM;
         end
         S_DENORM: w_next = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign  <= 1'b0;
         r_mag   <= '0;
         r_shift <= '0;
         r_y     <= '0;
         r_t     <= '0;
         r_phase <= 1'b0;
         r_cnt   <= '0;
         r_y_out <= '0;
         r_err   <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sign <= x_in[W-1];
                  r_mag  <= x_in[W-1] ? (-x_in) : x_in;
                  r_err  <= 1'b0;
                  r_sat  <= 1'b0;
               end
            end
            S_NORM: begin
               if (w_bad) begin
                  r_y_out <= '0;
                  r_err   <= 1'b1;
               end else begin
                  r_mag   <= r_mag << w_lz;
                  r_shift <= SW'(2 * (W - F)) - SW'(w_lz);
               end
            end
            S_SEED: begin
               r_y     <= w_lut[r_mag[W-2 -: LUT_BITS]];
               r_phase <= 1'b0;
               r_cnt   <= '0;
            end
            S_ITER: begin
               if (!r_phase) begin
                  r_t     <= w_prod_sh;
                  r_phase <= 1'b1;
               end else begin
                  r_y     <= w_prod_sh;
                  r_phase <= 1'b0;
                  r_cnt   <= r_cnt + 3'd1;
               end
            end
            S_DENORM: begin
               r_y_out <= r_sign ? (-w_r) : w_r;
               r_sat   <= w_sat;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_recip_nr.sv
// Directed bench for recip_nr: W=32, F=16, ITER=3, LUT_BITS=4, with one
// SIGNED_MODE=1 instance and one SIGNED_MODE=0 instance sharing clock/reset.
module tb_recip_nr;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        iv_s, ir_s, ov_s, or_s, err_s, sat_s, busy_s;
   logic [31:0] x_s, y_s;
   logic        iv_u, ir_u, ov_u, or_u, err_u, sat_u, busy_u;
   logic [31:0] x_u, y_u;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   recip_nr #(.W(32), .F(16), .ITER(3), .LUT_BITS(4), .SIGNED_MODE(1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .x_in(x_s),
      .out_valid(ov_s), .out_ready(or_s), .y_out(y_s), .out_err(err_s),
      .out_sat(sat_s), .busy(busy_s)
   );

   recip_nr #(.W(32), .F(16), .ITER(3), .LUT_BITS(4), .SIGNED_MODE(0)) u_dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_u), .in_ready(ir_u), .x_in(x_u),
      .out_valid(ov_u), .out_ready(or_u), .y_out(y_u), .out_err(err_u),
      .out_sat(sat_u), .busy(busy_u)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called just after the accept edge; waits (bounded) for out_valid.
   // lat is the edge index, counted from the accept edge, at which out_valid
   // is first sampled high; 0 means it never came.
   task automatic wait_out(input bit sel_u, output logic [31:0] y, output logic e,
                           output logic s, output int lat);
      lat = 0;
      y   = '0;
      e   = 1'b0;
      s   = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if ((sel_u ? ov_u : ov_s) === 1'b1) begin
            lat = k + 1;
            y   = sel_u ? y_u : y_s;
            e   = sel_u ? err_u : err_s;
            s   = sel_u ? sat_u : sat_s;
            break;
         end
      end
   endtask

   task automatic run_vec(input string tag, input bit sel_u, input logic [31:0] x,
                          input logic [31:0] ey, input logic ee, input logic es,
                          input int elat, input int tol);
      logic [31:0] y;
      logic        e, s;
      int          lat;
      int          d;
      @(negedge clk);
      check({tag, ".in_ready"}, sel_u ? ir_u : ir_s, 1);
      if (sel_u) begin x_u = x; iv_u = 1'b1; end
      else       begin x_s = x; iv_s = 1'b1; end
      @(posedge clk);
      #1;
      iv_s = 1'b0;
      iv_u = 1'b0;
      check({tag, ".busy"}, sel_u ? busy_u : busy_s, 1);
      wait_out(sel_u, y, e, s, lat);
      check({tag, ".lat"}, 64'(lat), 64'(elat));
      if (tol == 0) begin
         check({tag, ".y"}, y, ey);
      end else begin
         d = int'($signed(y)) - int'($signed(ey));
         if (d < 0) d = -d;
         check({tag, ".y_within_tol"}, (d <= tol), 1);
      end
      check({tag, ".err"}, e, ee);
      check({tag, ".sat"}, s, es);
   endtask

   initial begin
      logic [31:0] y;
      logic        e, s;
      int          lat;
      logic        seen;

      rst_n = 1'b0;
      iv_s = 1'b0; iv_u = 1'b0;
      x_s = '0;    x_u = '0;
      or_s = 1'b1; or_u = 1'b1;

      #12;
      check("rst.out_valid", ov_s, 0);
      check("rst.in_ready", ir_s, 1);
      check("rst.busy", busy_s, 0);
      check("rst.y_out", y_s, 0);
      check("rst.err", err_s, 0);
      check("rst.sat", sat_s, 0);
      check("rst_u.in_ready", ir_u, 1);

      // Operand presented as reset releases is taken on the very next edge.
      @(negedge clk);
      rst_n = 1'b1;
      x_s   = 32'h0002_0000;
      iv_s  = 1'b1;
      @(posedge clk);
      #1;
      iv_s = 1'b0;
      check("first_accept.busy", busy_s, 1);
      check("first_accept.in_ready", ir_s, 0);
      wait_out(1'b0, y, e, s, lat);
      check("two.lat", 64'(lat), 10);
      check("two.y", y, 32'h0000_8000);
      check("two.err", e, 0);
      check("two.sat", s, 0);

      run_vec("half",     0, 32'h0000_8000, 32'h0002_0000, 0, 0, 10, 0);
      run_vec("three",    0, 32'h0003_0000, 32'h0000_5555, 0, 0, 10, 2);
      run_vec("neg4",     0, 32'hFFFC_0000, 32'hFFFF_C000, 0, 0, 10, 0);
      run_vec("neg1",     0, 32'hFFFF_0000, 32'hFFFF_0000, 0, 0, 10, 0);
      run_vec("most_neg", 0, 32'h8000_0000, 32'hFFFF_FFFE, 0, 0, 10, 0);
      run_vec("zero",     0, 32'h0000_0000, 32'h0000_0000, 1, 0, 2,  0);
      run_vec("tiny",     0, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 10, 0);
      run_vec("neg_tiny", 0, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1, 10, 0);
      run_vec("after_sat",0, 32'h0002_0000, 32'h0000_8000, 0, 0, 10, 0);

      run_vec("u_neg4",   1, 32'hFFFC_0000, 32'h0000_0000, 1, 0, 2,  0);
      run_vec("u_two",    1, 32'h0002_0000, 32'h0000_8000, 0, 0, 10, 0);

      // Back-pressure: result and flags hold, new operands are ignored.
      or_s = 1'b0;
      run_vec("stall", 0, 32'h0000_8000, 32'h0002_0000, 0, 0, 10, 0);
      x_s  = 32'h0001_0000;
      iv_s = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("stall.out_valid", ov_s, 1);
         check("stall.y_hold", y_s, 32'h0002_0000);
         check("stall.err_hold", err_s, 0);
         check("stall.sat_hold", sat_s, 0);
         check("stall.in_ready", ir_s, 0);
      end
      iv_s = 1'b0;
      or_s = 1'b1;
      @(posedge clk);
      #1;
      check("handshake.out_valid", ov_s, 0);
      check("handshake.in_ready", ir_s, 1);

      // Reset in the middle of the iterations aborts the operand.
      @(negedge clk);
      x_s  = 32'h0003_0000;
      iv_s = 1'b1;
      @(posedge clk);
      #1;
      iv_s = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.out_valid", ov_s, 0);
      check("midrst.in_ready", ir_s, 1);
      check("midrst.busy", busy_s, 0);
      check("midrst.y_out", y_s, 0);
      check("midrst.err", err_s, 0);
      check("midrst.sat", sat_s, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         seen = seen | ov_s;
      end
      check("midrst.no_out_valid", seen, 0);
      run_vec("post_rst", 0, 32'h0002_0000, 32'h0000_8000, 0, 0, 10, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
